// File: rtl/shift_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// shift_tx_scheduler_if
// Bundles the requester handshakes, the external shift-register control and
// the serial beat handshake of shift_tx_scheduler.
//   slave  : scheduler side (drives readies, sr_* controls, serial outputs)
//   master : environment side (requesters, external register, serial sink)
// ----------------------------------------------------------------------------
interface shift_tx_scheduler_if #(
   parameter int unsigned DW = 4
);
   logic          req0_valid;
   logic [DW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [DW-1:0] req1_data;
   logic          req1_ready;
   logic          sr_load;
   logic          sr_en;
   logic [DW-1:0] sr_data;
   logic          sr_data_h;
   logic          sr_q0;
   logic          ser_out;
   logic          ser_valid;
   logic          ser_ready;
   logic          frame_start;
   logic          frame_end;
   logic          busy;
   logic          grant_id;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, sr_q0, ser_ready,
      output req0_ready, req1_ready, sr_load, sr_en, sr_data, sr_data_h,
             ser_out, ser_valid, frame_start, frame_end, busy, grant_id
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, sr_q0, ser_ready,
      input  req0_ready, req1_ready, sr_load, sr_en, sr_data, sr_data_h,
             ser_out, ser_valid, frame_start, frame_end, busy, grant_id
   );
endinterface

// File: rtl/shift_tx_scheduler.sv
// ----------------------------------------------------------------------------
// shift_tx_scheduler
// Round-robin arbiter between two parallel-word requesters that drives an
// external right-shift register and serializes each granted word LSB first
// over a valid/ready beat handshake. The next word is loaded on the last
// accepted beat of the current one, giving gapless back-to-back frames.
// Ports:
//   clk        : clock, rising edge
//   async_rst  : asynchronous, active-high reset
//   bus        : shift_tx_scheduler_if.slave
//                req0/req1 valid/data/ready  - requester handshakes (ready comb.)
//                sr_load/sr_en/sr_data/sr_data_h/sr_q0 - external register control
//                ser_out/ser_valid/ser_ready - serial beat handshake
//                frame_start/frame_end/busy/grant_id - frame status
// ----------------------------------------------------------------------------
module shift_tx_scheduler #(
   parameter int unsigned DW   = 4,
   parameter logic        FILL = 1'b0
) (
   input  logic                  clk,
   input  logic                  async_rst,
   shift_tx_scheduler_if.slave   bus
);

   localparam int unsigned       CW   = (DW > 2) ? $clog2(DW) : 1;
   localparam logic [CW-1:0]     LAST = CW'(DW - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          last_grant, last_grant_d;
   logic          grant_id_q, grant_id_d;

   logic          have_req_c;
   logic          winner_c;
   logic          open_c;
   logic          accept_c;
   logic          shift_en_c;

   // State register; last_grant resets to 1 so req0 wins the first tie.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         grant_id_q <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         last_grant <= last_grant_d;
         grant_id_q <= grant_id_d;
      end
   end

   // Next-state, arbitration and beat control.
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      last_grant_d = last_grant;
      grant_id_d   = grant_id_q;
      open_c       = 1'b0;
      shift_en_c   = 1'b0;

      have_req_c = bus.req0_valid | bus.req1_valid;
      // Tie goes to the requester not served last; otherwise the lone requester.
      winner_c   = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;

      case (state)
         IDLE: begin
            open_c = 1'b1;
         end
         SHIFT: begin
            if (bus.ser_ready) begin
               if (cnt != LAST) begin
                  shift_en_c = 1'b1;
                  cnt_d      = cnt + CW'(1);
               end else begin
                  // Last beat accepted: slot opens for a back-to-back load.
                  open_c  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Readies are combinational, so they must be masked while reset is held.
      accept_c = open_c & have_req_c & ~async_rst;

      if (accept_c) begin
         state_d      = SHIFT;
         cnt_d        = '0;
         last_grant_d = winner_c;
         grant_id_d   = winner_c;
      end
   end

   assign bus.req0_ready  = accept_c & ~winner_c;
   assign bus.req1_ready  = accept_c &  winner_c;
   assign bus.sr_load     = accept_c;
   assign bus.sr_en       = shift_en_c;
   assign bus.sr_data     = accept_c ? (winner_c ? bus.req1_data : bus.req0_data) : '0;
   assign bus.sr_data_h   = FILL;
   assign bus.ser_out     = bus.sr_q0;
   assign bus.ser_valid   = (state == SHIFT);
   assign bus.busy        = (state == SHIFT);
   assign bus.frame_start = (state == SHIFT) && (cnt == '0);
   assign bus.frame_end   = (state == SHIFT) && (cnt == LAST);
   assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_shift_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_shift_tx_scheduler
// Bench for shift_tx_scheduler (DW=4, FILL=0) with an external right-shift
// register. A transaction-level reference model (beats remaining in the
// current word, round-robin pointer) predicts every output each cycle; a
// vector table and hand sequences cover the documented corner cases, then
// randomized requester/sink traffic with occasional resets runs against it.
// ----------------------------------------------------------------------------
module tb_shift_tx_scheduler;

   localparam int unsigned DW = 4;

   logic clk = 1'b0;
   logic async_rst;

   always #5 clk = ~clk;

   shift_tx_scheduler_if #(.DW(DW)) bus ();

   shift_tx_scheduler #(.DW(DW), .FILL(1'b0)) dut (
      .clk       (clk),
      .async_rst (async_rst),
      .bus       (bus)
   );

   // External right-shift register; load has priority over enable.
   logic [DW-1:0] sr_q;
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst)       sr_q <= '0;
      else if (bus.sr_load) sr_q <= bus.sr_data;
      else if (bus.sr_en)   sr_q <= {bus.sr_data_h, sr_q[DW-1:1]};
   end
   assign bus.sr_q0 = sr_q[0];

   int n_vec = 0;
   int n_err = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            m_beats;     // serial beats still owed for the current word
   logic [DW-1:0] m_word;
   logic          m_last;
   logic          m_grant;
   logic          m_acc;
   logic          m_win;
   logic [DW-1:0] m_acc_word;

   task automatic model_reset();
      m_beats = 0;
      m_last  = 1'b1;
      m_grant = 1'b0;
      m_acc   = 1'b0;
   endtask

   task automatic model_check();
      logic open;
      if (async_rst) model_reset();
      open       = (m_beats == 0) || (m_beats == 1 && bus.ser_ready);
      m_win      = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      m_acc      = open && (bus.req0_valid || bus.req1_valid) && !async_rst;
      m_acc_word = m_win ? bus.req1_data : bus.req0_data;

      cmp("req0_ready",  32'(bus.req0_ready),  32'(m_acc && !m_win));
      cmp("req1_ready",  32'(bus.req1_ready),  32'(m_acc && m_win));
      cmp("sr_load",     32'(bus.sr_load),     32'(m_acc));
      cmp("sr_en",       32'(bus.sr_en),       32'(m_beats > 1 && bus.ser_ready));
      cmp("sr_data",     32'(bus.sr_data),     32'(m_acc ? m_acc_word : '0));
      cmp("sr_data_h",   32'(bus.sr_data_h),   32'(1'b0));
      cmp("ser_valid",   32'(bus.ser_valid),   32'(m_beats > 0));
      cmp("busy",        32'(bus.busy),        32'(m_beats > 0));
      cmp("frame_start", 32'(bus.frame_start), 32'(m_beats == int'(DW)));
      cmp("frame_end",   32'(bus.frame_end),   32'(m_beats == 1));
      cmp("grant_id",    32'(bus.grant_id),    32'(m_grant));
      if (m_beats > 0)
         cmp("ser_out",  32'(bus.ser_out),     32'(m_word[int'(DW) - m_beats]));
      cmp("ser_out_eq_q0", 32'(bus.ser_out),   32'(bus.sr_q0));
      cmp("load_en_excl",  32'(bus.sr_load & bus.sr_en),       32'(1'b0));
      cmp("ready_excl",    32'(bus.req0_ready & bus.req1_ready), 32'(1'b0));
   endtask

   task automatic model_update();
      if (async_rst) begin
         model_reset();
      end else if (m_acc) begin
         m_beats = int'(DW);
         m_word  = m_acc_word;
         m_last  = m_win;
         m_grant = m_win;
      end else if (m_beats > 0 && bus.ser_ready) begin
         m_beats--;
      end
   endtask

   task automatic drive(input logic v0, input logic [DW-1:0] d0, input logic v1,
                        input logic [DW-1:0] d1, input logic sr, input logic rst);
      bus.req0_valid = v0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_data  = d1;
      bus.ser_ready  = sr;
      async_rst      = rst;
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          v0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [DW-1:0] d1;
      logic          sr;
      logic          rst;
      logic          e_r0;
      logic          e_r1;
      logic          e_sv;
      logic          e_so;
      logic          e_fs;
      logic          e_fe;
      logic          chk_so;
   } vec_t;

   function automatic vec_t mk(logic v0, logic [DW-1:0] d0, logic v1, logic [DW-1:0] d1,
                               logic sr, logic rst, logic r0, logic r1, logic sv,
                               logic so, logic fs, logic fe, logic cs);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.sr = sr; v.rst = rst;
      v.e_r0 = r0; v.e_r1 = r1; v.e_sv = sv; v.e_so = so;
      v.e_fs = fs; v.e_fe = fe; v.chk_so = cs;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      logic          grants[$];
      logic          bits[$];
      logic [DW-1:0] wexp;
      logic          rv0, rv1, acc0, acc1;
      logic [DW-1:0] rd0, rd1;

      model_reset();
      m_word = '0; m_win = 1'b0; m_acc_word = '0;

      //            v0 d0    v1 d1    sr rst  r0 r1 sv so fs fe cs
      // reset holds readies low even with both requesting, then idle
      tbl.push_back(mk(1, 4'hB, 1, 4'h5, 1, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
      // single word 1011: bits 1,1,0,1 then idle
      tbl.push_back(mk(1, 4'hB, 0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
      // word 0110 with a 3-cycle stall at cnt==2
      tbl.push_back(mk(1, 4'h6, 0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 0, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
      // req0 word 1001; req1 (0110) raised at cnt==1, accepted only at cnt==3
      tbl.push_back(mk(1, 4'h9, 0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 4'h6, 1, 0,  0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 4'h6, 1, 0,  0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 1, 4'h6, 1, 0,  0, 1, 1, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 0, 1, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
      // reset at cnt==2 abandons the word; tie afterwards goes to req0
      tbl.push_back(mk(1, 4'hB, 0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 4'hB, 0, 4'h0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'hC, 1, 4'h3, 1, 0,  1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 1, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 1, 0,  0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].sr, tbl[i].rst);
         sample();
         cmp($sformatf("row%0d_req0_ready", i),  32'(bus.req0_ready),  32'(tbl[i].e_r0));
         cmp($sformatf("row%0d_req1_ready", i),  32'(bus.req1_ready),  32'(tbl[i].e_r1));
         cmp($sformatf("row%0d_ser_valid", i),   32'(bus.ser_valid),   32'(tbl[i].e_sv));
         cmp($sformatf("row%0d_busy", i),        32'(bus.busy),        32'(tbl[i].e_sv));
         cmp($sformatf("row%0d_frame_start", i), 32'(bus.frame_start), 32'(tbl[i].e_fs));
         cmp($sformatf("row%0d_frame_end", i),   32'(bus.frame_end),   32'(tbl[i].e_fe));
         if (tbl[i].chk_so)
            cmp($sformatf("row%0d_ser_out", i),  32'(bus.ser_out),     32'(tbl[i].e_so));
         advance();
      end

      // Both requesters held valid: grants alternate 0,1,0,1 with no idle beats.
      drive(0, '0, 0, '0, 1, 1);
      sample();
      advance();
      for (int c = 0; c < 17; c++) begin
         drive(1, 4'hA, 1, 4'h5, 1, 0);
         sample();
         if (bus.frame_start) grants.push_back(bus.grant_id);
         if (bus.ser_valid)   bits.push_back(bus.ser_out);
         advance();
      end
      cmp("alt_grant_count", 32'(grants.size()), 32'(4));
      cmp("alt_bit_count",   32'(bits.size()),   32'(16));
      foreach (grants[f]) begin
         if (f < 4) cmp($sformatf("alt_grant%0d", f), 32'(grants[f]), 32'(f % 2));
      end
      foreach (bits[b]) begin
         if (b < 16) begin
            wexp = ((b / 4) % 2 == 0) ? 4'hA : 4'h5;
            cmp($sformatf("alt_bit%0d", b), 32'(bits[b]), 32'(wexp[b % 4]));
         end
      end
      for (int c = 0; c < 6; c++) begin
         drive(0, '0, 0, '0, 1, 0);
         sample();
         advance();
      end

      // Randomized traffic; requesters hold their word until accepted.
      rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0;
      for (int c = 0; c < 3000; c++) begin
         drive(rv0, rd0, rv1, rd1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0));
         sample();
         acc0 = bus.req0_ready;
         acc1 = bus.req1_ready;
         advance();
         if (!rv0 || acc0) begin
            rv0 = ($urandom_range(0, 2) != 0);
            rd0 = DW'($urandom);
         end
         if (!rv1 || acc1) begin
            rv1 = ($urandom_range(0, 2) != 0);
            rd1 = DW'($urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/shift_tx_scheduler.md
SHIFT_TX_SCHEDULER -- requirements
Module: shift_tx_scheduler

Interface
REQ-001 The block SHALL have parameter DW, default 4, meaning word width of the controlled shift register (DW >= 2).
REQ-002 The block SHALL have parameter FILL, default 1'b0, meaning the bit driven on sr_data_h (shifted into the register MSB).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 async_rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid, req1_valid  input  1 each  requester word available.
REQ-006 req0_data, req1_data  input  DW each  requester parallel word.
REQ-007 req0_ready, req1_ready  output  1 each  word accepted this cycle (combinational).
REQ-008 sr_load  output  1  parallel-load strobe to the external right-shift register (load has priority over enable there).
REQ-009 sr_en  output  1  shift-right enable to the external register.
REQ-010 sr_data  output  DW  parallel word to the external register.
REQ-011 sr_data_h  output  1  MSB fill bit to the external register, always FILL.
REQ-012 sr_q0  input  1  bit 0 of the external register.
REQ-013 ser_out  output  1  serial bit, equal to sr_q0.
REQ-014 ser_valid, ser_ready  output / input  1 each  serial beat handshake.
REQ-015 frame_start, frame_end  output  1 each  first / last beat of a word.
REQ-016 busy  output  1  a word is being serialized.
REQ-017 grant_id  output  1  requester owning the current frame.

Function
REQ-018 The FSM SHALL have states IDLE and SHIFT, a beat counter cnt (0..DW-1) and a last_grant flag.
REQ-019 Arbitration SHALL be round-robin: one valid requester wins; both valid -> the one not equal to last_grant wins; last_grant updates on every acceptance.
REQ-020 In IDLE with a winner: winner's ready=1, sr_load=1, sr_data=winner data, sr_en=0; next state SHIFT, cnt=0, grant_id=winner.
REQ-021 In IDLE with no valid request: both ready=0, sr_load=0, sr_en=0, state holds.
REQ-022 In SHIFT: ser_valid=1, busy=1, frame_start=(cnt==0), frame_end=(cnt==DW-1); words SHALL be emitted LSB first.
REQ-023 In SHIFT with ser_ready=0: sr_load=0, sr_en=0, cnt and state hold, ready outputs 0 (stall, ser_out stable).
REQ-024 In SHIFT with ser_ready=1 and cnt<DW-1: sr_en=1, sr_load=0, cnt increments.
REQ-025 In SHIFT with ser_ready=1 and cnt==DW-1 and a winner exists: winner accepted exactly as REQ-020 (back-to-back, zero idle beats), state stays SHIFT, cnt=0.
REQ-026 In SHIFT with ser_ready=1 and cnt==DW-1 and no valid request: sr_load=0, sr_en=0, next state IDLE.
REQ-027 Request valid in SHIFT before the last accepted beat SHALL not be accepted; ready=0 and the requester holds its word.
REQ-028 Latency: word accepted in cycle T SHALL present bit 0 on ser_out in cycle T+1; an unstalled word occupies DW consecutive beats.
REQ-029 sr_load and sr_en SHALL never both be 1; at most one ready SHALL be 1 per cycle.
REQ-030 In IDLE, ser_valid, frame_start, frame_end and busy SHALL be 0.

Reset
REQ-031 async_rst=1 SHALL immediately force state IDLE, cnt=0, last_grant=1 (req0 wins first tie), grant_id=0.
REQ-032 Under reset all outputs SHALL be 0 except sr_data_h=FILL and sr_data=0; ser_out follows sr_q0.
REQ-033 Reset mid-frame SHALL abandon the word without completion; first cycle after release behaves as IDLE.

Verification (DW=4, FILL=0, bench instantiates a matching right-shift register)
REQ-034 req0_valid with 4'b1011, ser_ready=1 -> req0_ready pulse T; ser_out 1,1,0,1 at T+1..T+4; frame_start at T+1, frame_end at T+4; busy low at T+5.
REQ-035 Both valid continuously (req0=4'hA, req1=4'h5) -> grants alternate 0,1,0,1; frames gapless; ser_out 0101 1010 0101 ...
REQ-036 ser_ready low for 3 cycles at cnt==2 -> ser_out, cnt, frame_end hold; frame completes 3 cycles late with correct bits; sr_en=0 during stall.
REQ-037 req1 valid asserted at cnt==1 of req0 frame -> req1_ready only at cnt==3 beat; req1 bit 0 appears next cycle.
REQ-038 async_rst pulse at cnt==2 -> outputs 0 same cycle; after release with req0_valid, new frame starts from cnt=0 with req0 winning.
REQ-039 Every cycle: assert not(sr_load and sr_en), not(req0_ready and req1_ready), ser_out==sr_q0.
